// File: rtl/sram_burst_ctrl.sv
// SRAM controller: single-word write-through stores and line-fill read bursts
// over one bidirectional data bus, with a fixed wait-state count per access.
module sram_burst_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 17,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 5,
   parameter int BURST_LEN   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          write_en,
   input  logic                          read_en,
   input  logic                          hit,
   input  logic [31:0]                   address,
   input  logic [DATA_W-1:0]             writeData,
   output logic [BURST_LEN*DATA_W-1:0]   readData,
   output logic                          ready,
   inout  wire  [DATA_W-1:0]             SRAM_DQ,
   output logic [ADDR_W-1:0]             SRAM_ADDR,
   output logic                          SRAM_WE_N
);

   localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WAIT_CYCLES);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   state_t              state;
   state_t              next_state;
   logic [CNT_W-1:0]    wait_cnt;
   logic [BEAT_W-1:0]   beat_idx;
   logic [DATA_W-1:0]   wdata;
   logic [31:0]         byte_off;
   logic [ADDR_W-1:0]   waddr;
   logic                beat_end;
   logic                last_beat;
   logic                dq_oe;
   logic                unused_bits;

   // Addresses below the base wrap modulo 2^32 and are then truncated.
   assign byte_off    = address - 32'(BASE_ADDR);
   assign waddr       = byte_off[ADDR_W+1:2];
   assign unused_bits = ^{byte_off[1:0], byte_off >> (ADDR_W + 2)};

   assign beat_end  = (wait_cnt == LAST_CNT);
   assign last_beat = (beat_idx == LAST_BEAT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (write_en)             next_state = WRITE;
            else if (read_en && !hit) next_state = READ;
         end
         WRITE:   if (beat_end) next_state = DONE;
         READ:    if (beat_end && last_beat) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      dq_oe = 1'b0;
      case (state)
         IDLE:    ready = !write_en && (!read_en || hit);
         WRITE:   dq_oe = 1'b1;
         DONE:    ready = 1'b1;
         default: ;
      endcase
   end

   assign SRAM_DQ = dq_oe ? wdata : {DATA_W{1'bz}};

   // Address, write strobe, wait counter and line capture; a hit never touches these.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt  <= '0;
         beat_idx  <= '0;
         wdata     <= '0;
         readData  <= '0;
         SRAM_ADDR <= '0;
         SRAM_WE_N <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               beat_idx <= '0;
               if (write_en) begin
                  SRAM_ADDR <= waddr;
                  wdata     <= writeData;
                  SRAM_WE_N <= 1'b0;
               end else if (read_en && !hit) begin
                  SRAM_ADDR <= waddr & LINE_MASK;
               end
            end
            WRITE: begin
               if (beat_end) begin
                  wait_cnt  <= '0;
                  SRAM_WE_N <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            READ: begin
               if (beat_end) begin
                  readData[int'(beat_idx)*DATA_W +: DATA_W] <= SRAM_DQ;
                  SRAM_ADDR <= SRAM_ADDR + ADDR_W'(1);
                  beat_idx  <= beat_idx + BEAT_W'(1);
                  wait_cnt  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl: default build plus a zero-wait, four-beat build,
// each attached to a small behavioural SRAM that drives the bus whenever WE_N is high.
module tb_sram_burst_ctrl;

   logic        clk;
   logic        rst;

   logic        write_en, read_en, hit;
   logic [31:0] address, write_data;
   logic [63:0] read_data1;
   logic        ready1;
   wire  [31:0] dq1;
   logic [16:0] addr1;
   logic        we_n1;

   logic         write_en2, read_en2, hit2;
   logic [31:0]  address2, write_data2;
   logic [127:0] read_data2;
   logic         ready2;
   wire  [31:0]  dq2;
   logic [16:0]  addr2;
   logic         we_n2;

   logic [31:0] mem1 [0:15];
   logic [31:0] mem2 [0:15];

   int vectors;
   int miscompares;

   sram_burst_ctrl dut1 (
      .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .hit(hit),
      .address(address), .writeData(write_data), .readData(read_data1), .ready(ready1),
      .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we_n1)
   );

   sram_burst_ctrl #(.WAIT_CYCLES(0), .BURST_LEN(4)) dut2 (
      .clk(clk), .rst(rst), .write_en(write_en2), .read_en(read_en2), .hit(hit2),
      .address(address2), .writeData(write_data2), .readData(read_data2), .ready(ready2),
      .SRAM_DQ(dq2), .SRAM_ADDR(addr2), .SRAM_WE_N(we_n2)
   );

   assign dq1 = we_n1 ? mem1[addr1[3:0]] : 32'hz;
   assign dq2 = we_n2 ? mem2[addr2[3:0]] : 32'hz;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic re, input logic h,
                                input logic [31:0] addr, input logic [31:0] wd);
      write_en   = we;
      read_en    = re;
      hit        = h;
      address    = addr;
      write_data = wd;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 16; i++) begin
         mem1[i] = 32'h0;
         mem2[i] = 32'hA000_0000 + i;
      end
      mem1[0] = 32'h5A5A_5A5A;
      mem1[2] = 32'h1111_1111;
      mem1[3] = 32'h2222_2222;

      rst = 1'b0;
      applyStimulus(0, 0, 0, 32'd0, 32'd0);
      write_en2 = 0; read_en2 = 0; hit2 = 0; address2 = 0; write_data2 = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Reset state with the SRAM model free to drive the released bus
      @(negedge clk);
      checkOutput("rst_we_n", 128'(we_n1), 128'd1);
      checkOutput("rst_dq_released", 128'(dq1), 128'h5A5A5A5A);
      checkOutput("rst_read_data", 128'(read_data1), 128'd0);
      checkOutput("rst_ready", 128'(ready1), 128'd1);
      checkOutput("rst_addr", 128'(addr1), 128'd0);
      checkOutput("rst_ready2", 128'(ready2), 128'd1);

      // Single write: 1032 -> word 2, six WRITE cycles, DONE in cycle 7
      nextCycle();
      applyStimulus(1, 0, 0, 32'd1032, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("wr_c0_ready", 128'(ready1), 128'd0);
      for (int c = 1; c <= 6; c++) begin
         nextCycle();
         @(negedge clk);
         checkOutput("wr_addr", 128'(addr1), 128'd2);
         checkOutput("wr_we_n", 128'(we_n1), 128'd0);
         checkOutput("wr_dq", 128'(dq1), 128'hDEADBEEF);
         checkOutput("wr_ready", 128'(ready1), 128'd0);
      end
      nextCycle();
      @(negedge clk);
      checkOutput("wr_c7_ready", 128'(ready1), 128'd1);
      checkOutput("wr_c7_we_n", 128'(we_n1), 128'd1);
      nextCycle();
      applyStimulus(0, 0, 0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("wr_idle_ready", 128'(ready1), 128'd1);

      // Line fill at 1036: aligned to word 2, beats at words 2 and 3, DONE in cycle 13
      nextCycle();
      applyStimulus(0, 1, 0, 32'd1036, 32'd0);
      @(negedge clk);
      checkOutput("rd_c0_ready", 128'(ready1), 128'd0);
      for (int c = 1; c <= 12; c++) begin
         nextCycle();
         @(negedge clk);
         checkOutput("rd_addr", 128'(addr1), (c <= 6) ? 128'd2 : 128'd3);
         checkOutput("rd_ready", 128'(ready1), 128'd0);
         if (c == 7) checkOutput("rd_word0", 128'(read_data1[31:0]), 128'h11111111);
      end
      nextCycle();
      @(negedge clk);
      checkOutput("rd_c13_ready", 128'(ready1), 128'd1);
      checkOutput("rd_line", 128'(read_data1), 128'h22222222_11111111);

      // Hit bypass right after DONE: ready in the same cycle, nothing changes
      nextCycle();
      applyStimulus(0, 1, 1, 32'd2000, 32'd0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checkOutput("hit_ready", 128'(ready1), 128'd1);
         checkOutput("hit_we_n", 128'(we_n1), 128'd1);
         checkOutput("hit_addr", 128'(addr1), 128'd4);
         checkOutput("hit_line", 128'(read_data1), 128'h22222222_11111111);
         nextCycle();
      end

      // Write wins when both enables are high: 1044 -> word 5
      applyStimulus(1, 1, 0, 32'd1044, 32'h12345678);
      @(negedge clk);
      checkOutput("pri_c0_ready", 128'(ready1), 128'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("pri_we_n", 128'(we_n1), 128'd0);
      checkOutput("pri_dq", 128'(dq1), 128'h12345678);
      checkOutput("pri_addr", 128'(addr1), 128'd5);
      repeat (6) nextCycle();
      @(negedge clk);
      checkOutput("pri_c7_ready", 128'(ready1), 128'd1);
      checkOutput("pri_line_kept", 128'(read_data1), 128'h22222222_11111111);
      nextCycle();
      applyStimulus(0, 0, 0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("pri_idle_ready", 128'(ready1), 128'd1);

      // Reset asserted in cycle 3 of a write aborts it at once
      nextCycle();
      applyStimulus(1, 0, 0, 32'd1048, 32'hCAFEF00D);
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkOutput("abort_pre_we_n", 128'(we_n1), 128'd0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(0, 0, 0, 32'd0, 32'd0);
      #1;
      checkOutput("abort_we_n", 128'(we_n1), 128'd1);
      checkOutput("abort_dq_released", 128'(dq1), 128'h5A5A5A5A);
      checkOutput("abort_addr", 128'(addr1), 128'd0);
      checkOutput("abort_line", 128'(read_data1), 128'd0);
      checkOutput("abort_ready", 128'(ready1), 128'd1);
      nextCycle();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_after_we_n", 128'(we_n1), 128'd1);
      checkOutput("abort_after_ready", 128'(ready1), 128'd1);

      // Zero wait states, four-beat line at 1024: one beat per cycle, DONE in cycle 5
      nextCycle();
      read_en2 = 1'b1;
      address2 = 32'd1024;
      @(negedge clk);
      checkOutput("p_c0_ready", 128'(ready2), 128'd0);
      for (int c = 1; c <= 4; c++) begin
         nextCycle();
         @(negedge clk);
         checkOutput("p_addr", 128'(addr2), 128'(c - 1));
         checkOutput("p_ready", 128'(ready2), 128'd0);
         if (c >= 2)
            checkOutput("p_word", 128'(read_data2[(c-2)*32 +: 32]), 128'(32'hA0000000 + c - 2));
      end
      nextCycle();
      @(negedge clk);
      checkOutput("p_c5_ready", 128'(ready2), 128'd1);
      checkOutput("p_line", read_data2, 128'hA0000003_A0000002_A0000001_A0000000);
      nextCycle();
      read_en2 = 1'b0;
      @(negedge clk);
      checkOutput("p_idle_ready", 128'(ready2), 128'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
